// File: rtl/cmp_sched_pkg.sv
// Shared types and constants for the comparator scheduler.
// Port identifiers, buffer state encoding and small helpers used by the
// scheduler top and its arbiter.
package cmp_sched_pkg;

    // Requester identifiers: branch unit and ALU set-less-than path.
    localparam logic CMP_PORT_BR  = 1'b0;
    localparam logic CMP_PORT_ALU = 1'b1;

    // Default tag width carried from request to response.
    localparam int CMP_TAGW = 4;

    // Response buffer occupancy.
    typedef enum logic {
        CMP_ST_EMPTY = 1'b0,
        CMP_ST_FULL  = 1'b1
    } cmp_state_e;

    // One-hot response valid for a given owner port.
    function automatic logic [1:0] port_onehot(input logic port);
        return (port == CMP_PORT_ALU) ? 2'b10 : 2'b01;
    endfunction

    // Width of the starvation counter; at least one bit.
    function automatic int starve_w(input int lim);
        return (lim < 1) ? 1 : $clog2(lim + 1);
    endfunction

endpackage

// File: rtl/cmp_sched_arb.sv
// Two-port arbiter for the comparator scheduler.
// FIXED_PRIO=1: port 0 wins unless port 1 has lost STARVE_LIM accepted
// arbitrations in a row. FIXED_PRIO=0: round-robin on a preferred-port
// pointer. The grant is a pure function of req_valid and the arbiter
// registers; the registers only move when the grant is actually accepted.
module cmp_arb
    import cmp_sched_pkg::*;
#(
    parameter int FIXED_PRIO = 1,
    parameter int STARVE_LIM = 3,
    parameter int SW         = starve_w(STARVE_LIM)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [1:0]    req_valid,
    input  logic          accept,
    output logic [1:0]    grant,
    output logic [SW-1:0] starve_cnt,
    output logic          rr_ptr
);

    logic starved;

    // Select the winning port from the current requests.
    always_comb begin
        grant   = 2'b00;
        starved = (starve_cnt == SW'(STARVE_LIM));
        if (FIXED_PRIO != 0) begin
            if (req_valid[CMP_PORT_BR] && !(starved && req_valid[CMP_PORT_ALU])) begin
                grant = 2'b01;
            end else if (req_valid[CMP_PORT_ALU]) begin
                grant = 2'b10;
            end
        end else begin
            if (req_valid == 2'b11) begin
                grant = port_onehot(rr_ptr);
            end else begin
                // A lone requester always wins; no requester, no grant.
                grant = req_valid;
            end
        end
    end

    // Track port-1 losses and the round-robin preference on each accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
            rr_ptr     <= CMP_PORT_BR;
        end else if (accept) begin
            if (grant[CMP_PORT_ALU]) begin
                starve_cnt <= '0;
            end else if (req_valid[CMP_PORT_ALU] && !starved) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
            // The port just served becomes the less preferred one.
            rr_ptr <= grant[CMP_PORT_BR] ? CMP_PORT_ALU : CMP_PORT_BR;
        end
    end

endmodule

// File: rtl/comp.sv
// Shared 64-bit comparator: less-than under selectable signedness plus
// equality. Purely combinational.
module comp #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            unsigned_mode,
    output logic            lt_flag,
    output logic            eq_flag
);

    // Compare the two operands; signedness only affects the less-than result.
    always_comb begin
        eq_flag = (op1 == op2);
        if (unsigned_mode) begin
            lt_flag = (op1 < op2);
        end else begin
            lt_flag = ($signed(op1) < $signed(op2));
        end
    end

endmodule

// File: rtl/cmp_sched.sv
// Comparator scheduler: shares one comparator between the branch unit
// (port 0) and the ALU set-less-than path (port 1). One request is accepted
// per cycle, compared, and its result held in a one-entry response buffer
// until the owning port takes it.
//
// Handshake: a request transfers on a rising edge where req_valid[p] and
// req_ready[p] are both high; a response transfers on a rising edge where
// rsp_valid[p] and rsp_ready[p] are both high. A requester keeps operands,
// mode and tag stable while req_valid[p] && !req_ready[p], and never drops a
// valid request. req_ready is combinational on req_valid, rsp_ready and the
// buffer state, and has at most one bit set.
module cmp_sched
    import cmp_sched_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int TAGW       = CMP_TAGW,
    parameter int FIXED_PRIO = 1,
    parameter int STARVE_LIM = 3,
    parameter int SW         = starve_w(STARVE_LIM)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*XLEN-1:0] req_op1,
    input  logic [2*XLEN-1:0] req_op2,
    input  logic [1:0]        req_unsigned,
    input  logic [2*TAGW-1:0] req_tag,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic              rsp_lt,
    output logic              rsp_eq,
    output logic [TAGW-1:0]   rsp_tag,
    output logic              busy,
    output logic              dbg_state,
    output logic [SW-1:0]     dbg_starve
);

    cmp_state_e      state;
    cmp_state_e      state_nxt;
    logic [1:0]      grant;
    logic            accept;
    logic            drain;
    logic            owner;
    logic            sel;
    logic [XLEN-1:0] op1_sel;
    logic [XLEN-1:0] op2_sel;
    logic            uns_sel;
    logic [TAGW-1:0] tag_sel;
    logic            lt_c;
    logic            eq_c;
    logic            rr_ptr;

    cmp_arb #(
        .FIXED_PRIO (FIXED_PRIO),
        .STARVE_LIM (STARVE_LIM),
        .SW         (SW)
    ) u_arb (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .accept     (accept),
        .grant      (grant),
        .starve_cnt (dbg_starve),
        .rr_ptr     (rr_ptr)
    );

    // Steer the granted port's operands, mode and tag to the comparator.
    always_comb begin
        sel     = grant[CMP_PORT_ALU];
        op1_sel = sel ? req_op1[XLEN +: XLEN] : req_op1[0 +: XLEN];
        op2_sel = sel ? req_op2[XLEN +: XLEN] : req_op2[0 +: XLEN];
        uns_sel = sel ? req_unsigned[1] : req_unsigned[0];
        tag_sel = sel ? req_tag[TAGW +: TAGW] : req_tag[0 +: TAGW];
    end

    comp #(
        .XLEN (XLEN)
    ) u_comp (
        .op1           (op1_sel),
        .op2           (op2_sel),
        .unsigned_mode (uns_sel),
        .lt_flag       (lt_c),
        .eq_flag       (eq_c)
    );

    // Buffer state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= CMP_ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, accept and response-valid decode. Nothing is accepted
    // while reset is asserted, and a drain can free the buffer for a new
    // accept in the same cycle.
    always_comb begin
        state_nxt = state;
        drain     = 1'b0;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        busy      = 1'b0;
        if (reset_n) begin
            case (state)
                CMP_ST_EMPTY: begin
                    req_ready = grant;
                    if (grant != 2'b00) begin
                        state_nxt = CMP_ST_FULL;
                    end
                end
                CMP_ST_FULL: begin
                    busy      = 1'b1;
                    rsp_valid = port_onehot(owner);
                    drain     = rsp_ready[owner];
                    if (drain) begin
                        req_ready = grant;
                        state_nxt = (grant != 2'b00) ? CMP_ST_FULL : CMP_ST_EMPTY;
                    end
                end
                default: begin
                    state_nxt = CMP_ST_EMPTY;
                end
            endcase
        end
    end

    assign accept    = (req_ready != 2'b00);
    assign dbg_state = (state == CMP_ST_FULL);

    // Capture the comparison result, owner and tag on every accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner   <= CMP_PORT_BR;
            rsp_lt  <= 1'b0;
            rsp_eq  <= 1'b0;
            rsp_tag <= '0;
        end else if (accept) begin
            owner   <= sel;
            rsp_lt  <= lt_c;
            rsp_eq  <= eq_c;
            rsp_tag <= tag_sel;
        end
    end

endmodule
